// File: rtl/param_ram_pkg.sv
// Shared constants for the parameterised RAM: read-mode selectors and the
// clear-sequencer state encoding.
package param_ram_pkg;

  // Behaviour of Dout on a same-address write
  localparam int RD_FIRST = 0;  // Dout shows the word that was overwritten
  localparam int WR_FIRST = 1;  // Dout shows the word being written

  // Clear sequencer states
  typedef enum logic {
    ST_CLEAR = 1'b0,  // walking the array and writing zeros
    ST_IDLE  = 1'b1   // normal user access
  } clr_state_e;

endpackage

// File: rtl/param_ram_clr.sv
// Clear sequencer: after reset, walks every address once writing zero, then
// hands the array over to the user port. BUSY covers the whole walk.
module param_ram_clr
  import param_ram_pkg::*;
#(
  parameter int AW           = 8,
  parameter int CLEAR_ON_RST = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  output logic          busy,
  output logic          clr_we,
  output logic [AW-1:0] clr_addr
);

  clr_state_e    state_q, state_d;
  logic [AW-1:0] ptr_q, ptr_d;
  logic          busy_q, busy_d;

  // Next-state: advance the pointer while clearing, leave after the last word
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    if (state_q == ST_CLEAR) begin
      ptr_d = ptr_q + 1'b1;
      if (ptr_q == {AW{1'b1}}) begin
        state_d = ST_IDLE;
      end
    end
    busy_d = (state_d == ST_CLEAR);
  end

  // State, pointer and registered BUSY; reset restarts the walk from zero
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= (CLEAR_ON_RST != 0) ? ST_CLEAR : ST_IDLE;
      ptr_q   <= '0;
      busy_q  <= (CLEAR_ON_RST != 0);
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      busy_q  <= busy_d;
    end
  end

  assign busy     = busy_q;
  // No clear write lands on a reset edge, so reset never disturbs the array
  assign clr_we   = busy_q & rst_n;
  assign clr_addr = ptr_q;

endmodule

// File: rtl/param_ram.sv
// Single-port RAM with registered read, selectable read-first/write-first
// behaviour and an optional zero-fill sequence after reset.
module param_ram
  import param_ram_pkg::*;
#(
  parameter int DW           = 10,
  parameter int AW           = 8,
  parameter int RD_MODE      = 0,
  parameter int CLEAR_ON_RST = 1
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          EN,
  input  logic          WE,
  input  logic [AW-1:0] ADDR,
  input  logic [DW-1:0] Din,
  output logic [DW-1:0] Dout,
  output logic          Dvalid,
  output logic          BUSY
);

  localparam int DEPTH = 1 << AW;

  logic          busy;
  logic          clr_we;
  logic [AW-1:0] clr_addr;

  logic [DW-1:0] mem [DEPTH];

  logic          accept;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] rd_word;

  logic [DW-1:0] dout_q, dout_d;
  logic          dvalid_q, dvalid_d;

  param_ram_clr #(
    .AW           (AW),
    .CLEAR_ON_RST (CLEAR_ON_RST)
  ) u_clr (
    .clk      (CLK),
    .rst_n    (RST),
    .busy     (busy),
    .clr_we   (clr_we),
    .clr_addr (clr_addr)
  );

  // User access is locked out during clear and on reset edges
  assign accept = EN & ~busy & RST;

  // Write-port mux: the clear path owns the port while it runs
  always_comb begin
    mem_we    = clr_we | (accept & WE);
    mem_addr  = ADDR;
    mem_wdata = Din;
    if (clr_we) begin
      mem_addr  = clr_addr;
      mem_wdata = '0;
    end
  end

  // Array write; no reset so contents survive RST
  always_ff @(posedge CLK) begin
    if (mem_we) begin
      mem[mem_addr] <= mem_wdata;
    end
  end

  assign rd_word = mem[ADDR];

  // Read data selection; Dout holds when nothing is accepted
  always_comb begin
    dout_d   = dout_q;
    dvalid_d = 1'b0;
    if (accept) begin
      dvalid_d = 1'b1;
      if (WE && (RD_MODE == WR_FIRST)) begin
        dout_d = Din;
      end else begin
        dout_d = rd_word;
      end
    end
  end

  // Registered read port outputs
  always_ff @(posedge CLK) begin
    if (!RST) begin
      dout_q   <= '0;
      dvalid_q <= 1'b0;
    end else begin
      dout_q   <= dout_d;
      dvalid_q <= dvalid_d;
    end
  end

  assign Dout   = dout_q;
  assign Dvalid = dvalid_q;
  assign BUSY   = busy;

endmodule

// File: tb/tb_param_ram.sv
// Bench for param_ram: read-first and write-first instances share stimulus,
// a third instance covers the no-clear 16x16 configuration.
module tb_param_ram;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, en, we;
  logic [7:0] addr;
  logic [9:0] din;
  logic [9:0] dout_rf, dout_wf;
  logic       dvalid_rf, dvalid_wf, busy_rf, busy_wf;

  logic        n_rst, n_en, n_we;
  logic [3:0]  n_addr;
  logic [15:0] n_din, n_dout;
  logic        n_dvalid, n_busy;

  int checks   = 0;
  int failures = 0;

  logic [9:0]  q_rf[$];
  logic [9:0]  q_wf[$];
  logic [15:0] q_n[$];
  logic [9:0]  model[256];

  param_ram #(.DW(10), .AW(8), .RD_MODE(0), .CLEAR_ON_RST(1)) u_rf (
    .CLK(clk), .RST(rst), .EN(en), .WE(we), .ADDR(addr), .Din(din),
    .Dout(dout_rf), .Dvalid(dvalid_rf), .BUSY(busy_rf));

  param_ram #(.DW(10), .AW(8), .RD_MODE(1), .CLEAR_ON_RST(1)) u_wf (
    .CLK(clk), .RST(rst), .EN(en), .WE(we), .ADDR(addr), .Din(din),
    .Dout(dout_wf), .Dvalid(dvalid_wf), .BUSY(busy_wf));

  param_ram #(.DW(16), .AW(4), .RD_MODE(1), .CLEAR_ON_RST(0)) u_nc (
    .CLK(clk), .RST(n_rst), .EN(n_en), .WE(n_we), .ADDR(n_addr), .Din(n_din),
    .Dout(n_dout), .Dvalid(n_dvalid), .BUSY(n_busy));

  // One clock; outputs sampled on the falling edge, scoreboard popped on Dvalid
  task automatic cycle();
    logic [9:0]  e;
    logic [15:0] e16;
    @(posedge clk);
    @(negedge clk);
    if (dvalid_rf === 1'b1) begin
      checks++;
      if (q_rf.size() == 0) begin
        failures++;
        $display("FAIL rf_unexpected_dvalid got dout=%0d, required no Dvalid", dout_rf);
      end else begin
        e = q_rf.pop_front();
        if (dout_rf !== e) begin
          failures++;
          $display("FAIL rf_dout got=%0d required=%0d", dout_rf, e);
        end
      end
    end
    if (dvalid_wf === 1'b1) begin
      checks++;
      if (q_wf.size() == 0) begin
        failures++;
        $display("FAIL wf_unexpected_dvalid got dout=%0d, required no Dvalid", dout_wf);
      end else begin
        e = q_wf.pop_front();
        if (dout_wf !== e) begin
          failures++;
          $display("FAIL wf_dout got=%0d required=%0d", dout_wf, e);
        end
      end
    end
    if (n_dvalid === 1'b1) begin
      checks++;
      if (q_n.size() == 0) begin
        failures++;
        $display("FAIL nc_unexpected_dvalid got dout=%0h, required no Dvalid", n_dout);
      end else begin
        e16 = q_n.pop_front();
        if (n_dout !== e16) begin
          failures++;
          $display("FAIL nc_dout got=%0h required=%0h", n_dout, e16);
        end
      end
    end
  endtask

  // One accepted access on the shared 10x256 port, expectations from the model
  task automatic acc(input logic w, input logic [7:0] a, input logic [9:0] d);
    logic [9:0] old;
    logic [9:0] exp_wf;
    old    = model[a];
    exp_wf = w ? d : old;
    en = 1'b1; we = w; addr = a; din = d;
    q_rf.push_back(old);
    q_wf.push_back(exp_wf);
    if (w) model[a] = d;
    $display("acc we=%0b addr=%0d din=%0d exp_rf=%0d exp_wf=%0d", w, a, d, old, exp_wf);
    cycle();
    checks++;
    if (dvalid_rf !== 1'b1 || dvalid_wf !== 1'b1) begin
      failures++;
      $display("FAIL acc_dvalid got rf=%b wf=%b required 1", dvalid_rf, dvalid_wf);
    end
    en = 1'b0; we = 1'b0;
  endtask

  // One accepted access on the 16x16 no-clear instance
  task automatic acc_n(input logic w, input logic [3:0] a, input logic [15:0] d,
                       input logic [15:0] exp_d);
    n_en = 1'b1; n_we = w; n_addr = a; n_din = d;
    q_n.push_back(exp_d);
    $display("acc_nc we=%0b addr=%0d din=%0h exp=%0h", w, a, d, exp_d);
    cycle();
    checks++;
    if (n_dvalid !== 1'b1) begin
      failures++;
      $display("FAIL nc_dvalid got=%b required 1", n_dvalid);
    end
    n_en = 1'b0; n_we = 1'b0;
  endtask

  // Idle cycle: Dvalid must have dropped and every expected result consumed
  task automatic drain();
    cycle();
    checks++;
    if (dvalid_rf !== 1'b0 || dvalid_wf !== 1'b0 || n_dvalid !== 1'b0 ||
        q_rf.size() != 0 || q_wf.size() != 0 || q_n.size() != 0) begin
      failures++;
      $display("FAIL drain got dvalid rf=%b wf=%b nc=%b pending=%0d/%0d/%0d required 0",
               dvalid_rf, dvalid_wf, n_dvalid, q_rf.size(), q_wf.size(), q_n.size());
    end
  endtask

  task automatic zero_model();
    for (int i = 0; i < 256; i++) model[i] = '0;
  endtask

  task automatic test_reset();
    int cnt;
    rst = 1'b0; en = 1'b0;
    cycle(); cycle();
    checks++;
    if (dout_rf !== 10'd0 || dvalid_rf !== 1'b0 || dout_wf !== 10'd0 || dvalid_wf !== 1'b0) begin
      failures++;
      $display("FAIL reset_outputs got dout=%0d/%0d dvalid=%b/%b required 0", dout_rf, dout_wf, dvalid_rf, dvalid_wf);
    end
    checks++;
    if (busy_rf !== 1'b1 || busy_wf !== 1'b1 || n_busy !== 1'b0) begin
      failures++;
      $display("FAIL reset_busy got rf=%b wf=%b nc=%b required 1/1/0", busy_rf, busy_wf, n_busy);
    end
    rst = 1'b1;
    cnt = 0;
    while (busy_rf === 1'b1 && cnt < 600) begin
      cnt++;
      cycle();
    end
    $display("reset clear cycles=%0d", cnt);
    checks++;
    if (cnt != 256 || busy_wf !== 1'b0) begin
      failures++;
      $display("FAIL clear_length got=%0d (wf busy=%b) required 256", cnt, busy_wf);
    end
    zero_model();
    acc(1'b0, 8'd0, 10'd0);
    acc(1'b0, 8'd128, 10'd0);
    acc(1'b0, 8'd255, 10'd0);
    drain();
  endtask

  task automatic test_write_read();
    acc(1'b1, 8'd0, 10'd29);
    acc(1'b1, 8'd1, 10'd45);
    acc(1'b0, 8'd1, 10'd0);
    checks++;
    if (dout_rf !== 10'd45 || dout_wf !== 10'd45) begin
      failures++;
      $display("FAIL write_read got=%0d/%0d required 45", dout_rf, dout_wf);
    end
    drain();
  endtask

  task automatic test_mode();
    acc(1'b1, 8'd5, 10'd7);
    acc(1'b1, 8'd5, 10'd300);
    checks++;
    if (dout_rf !== 10'd7 || dout_wf !== 10'd300) begin
      failures++;
      $display("FAIL mode_same_addr got rf=%0d wf=%0d required 7/300", dout_rf, dout_wf);
    end
    acc(1'b0, 8'd5, 10'd0);
    checks++;
    if (dout_rf !== 10'd300 || dout_wf !== 10'd300) begin
      failures++;
      $display("FAIL mode_readback got rf=%0d wf=%0d required 300", dout_rf, dout_wf);
    end
    drain();
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 24; i++) begin
      acc(1'($urandom_range(0, 1)), 8'($urandom_range(0, 7)), 10'($urandom_range(0, 1023)));
    end
    drain();
  endtask

  task automatic test_busy_lockout();
    int cnt;
    int bad;
    rst = 1'b0;
    cycle(); cycle();
    en = 1'b1; we = 1'b1; din = 10'd99; addr = 8'd3;
    rst = 1'b1;
    cnt = 0; bad = 0;
    while (busy_rf === 1'b1 && cnt < 600) begin
      cnt++;
      cycle();
      if (dvalid_rf !== 1'b0 || dvalid_wf !== 1'b0 || dout_rf !== 10'd0 || dout_wf !== 10'd0) bad++;
    end
    en = 1'b0; we = 1'b0;
    $display("lockout clear cycles=%0d bad=%0d", cnt, bad);
    checks++;
    if (bad != 0 || cnt != 256) begin
      failures++;
      $display("FAIL busy_lockout got bad=%0d cycles=%0d required 0/256", bad, cnt);
    end
    zero_model();
    acc(1'b0, 8'd3, 10'd0);
    drain();
  endtask

  task automatic test_mid_clear_reset();
    int cnt;
    rst = 1'b0;
    cycle(); cycle();
    rst = 1'b1;
    repeat (100) cycle();
    checks++;
    if (busy_rf !== 1'b1) begin
      failures++;
      $display("FAIL mid_clear_busy got=%b required 1", busy_rf);
    end
    rst = 1'b0;
    cycle(); cycle();
    rst = 1'b1;
    cnt = 0;
    while (busy_rf === 1'b1 && cnt < 600) begin
      cnt++;
      cycle();
    end
    $display("mid-clear restart cycles=%0d", cnt);
    checks++;
    if (cnt != 256) begin
      failures++;
      $display("FAIL mid_clear_length got=%0d required 256", cnt);
    end
    zero_model();
    acc(1'b0, 8'd200, 10'd0);
    drain();
  endtask

  task automatic test_no_clear();
    int busy_seen;
    n_rst = 1'b0;
    cycle(); cycle();
    checks++;
    if (n_busy !== 1'b0 || n_dout !== 16'd0 || n_dvalid !== 1'b0) begin
      failures++;
      $display("FAIL nc_reset got busy=%b dout=%0h dvalid=%b required 0", n_busy, n_dout, n_dvalid);
    end
    n_rst = 1'b1;
    busy_seen = 0;
    acc_n(1'b1, 4'd15, 16'hBEEF, 16'hBEEF);
    if (n_busy !== 1'b0) busy_seen++;
    acc_n(1'b0, 4'd15, 16'h0000, 16'hBEEF);
    if (n_busy !== 1'b0) busy_seen++;
    checks++;
    if (n_dout !== 16'hBEEF) begin
      failures++;
      $display("FAIL nc_readback got=%0h required beef", n_dout);
    end
    for (int i = 0; i < 4; i++) begin
      cycle();
      if (n_busy !== 1'b0) busy_seen++;
    end
    checks++;
    if (busy_seen != 0) begin
      failures++;
      $display("FAIL nc_busy got %0d busy samples required 0", busy_seen);
    end
    drain();
  endtask

  initial begin
    rst = 1'b0; en = 1'b0; we = 1'b0; addr = '0; din = '0;
    n_rst = 1'b0; n_en = 1'b0; n_we = 1'b0; n_addr = '0; n_din = '0;
    zero_model();
    test_reset();
    test_write_read();
    test_mode();
    test_back_to_back();
    test_busy_lockout();
    test_mid_clear_reset();
    test_no_clear();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
